regfile_hazard_ctrl: RTL and testbench
======================================

Name: regfile_hazard_ctrl

Overview:
Hazard controller that sequences use of the 32x32 register file in the 5-stage trace pipeline. It keeps a shadow pipeline of destination-register metadata for the EX, MEM and WB stages. From that state it generates load-use stalls and per-operand forwarding selects for the ID/EX operand muxes. It also closes the same-cycle write/read window of the register file, whose writes commit on the clock edge, by forwarding from WB.

Parameters:
- AW, 5, register address width (32 registers; register 0 is hardwired zero)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous reset, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  AW  source register 1 of the ID instruction
- id_rs2  in  AW  source register 2 of the ID instruction
- id_rs1_used  in  1  rs1 is actually read
- id_rs2_used  in  1  rs2 is actually read
- id_rd  in  AW  destination of the ID instruction
- id_we  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load (result available after MEM)
- flush  in  1  branch/jump taken; kill the ID instruction
- freeze  in  1  external hold (memory wait); no stage advances
- stall  out  1  hold PC and IF/ID, inject bubble into EX
- fwd1_sel  out  2  rs1 source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 WB write data
- fwd2_sel  out  2  rs2 source, same encoding as fwd1_sel
- stall_cnt  out  CNT_W  count of cycles with stall=1, saturating

Behaviour:
- State: three slots, EX, MEM and WB. Each slot holds {v, rd, we, ld}.
- Reset (rst_n=0, asynchronous): all slot fields are cleared and stall_cnt is cleared. Outputs then read stall=0, fwd1_sel=0, fwd2_sel=0.
- Hazard test per slot S and operand n: hit(S,n) = S.v & S.we & (S.rd != 0) & (S.rd == id_rsn) & id_rsn_used & id_valid.
- Forwarding selects are combinational from registered state. Priority is youngest first:
  - hit(EX,n) & !EX.ld → 1
  - else hit(MEM,n) → 2
  - else hit(WB,n) → 3
  - else → 0
- stall = (hit(EX,1) | hit(EX,2)) & EX.ld & !flush. This is combinational and costs exactly one bubble per load-use pair.
- When stall=1, fwd selects are don't-care; they are driven to 0.
- Advance on posedge, when freeze=0:
  - WB ← MEM
  - MEM ← EX
  - EX ← bubble (v=0) if stall | flush | !id_valid
  - otherwise EX ← {1, id_rd, id_we, id_is_load}
- freeze=1: all slots hold and stall_cnt holds. freeze has priority over flush and stall.
- flush and stall in the same cycle: flush wins, so stall=0 and the ID instruction is killed.
- stall_cnt increments when stall=1 & freeze=0. At all-ones it saturates and holds.
- rd=0 never produces a hit, a forward or a stall.
- Reset mid-operation: all in-flight metadata is dropped immediately. The first cycle after release behaves as an empty pipeline.
- Latency:
  - Load-use: 1 stall cycle. On the following cycle the load sits in MEM, so fwd=2.
  - ALU-use: 0 stall cycles, fwd=1.

Decomposition:
- Shared package holds:
  - FWD_RF=2'd0, FWD_EXM=2'd1, FWD_MWB=2'd2, FWD_WB=2'd3
  - the slot struct {v, rd, we, ld}
  - AW default
- One natural sub-module: hazard_slot_cmp. It compares one slot against one source operand and returns hit. It is instantiated 6 times (3 slots x 2 operands).
- Priority encoding, the stall equation and the counter stay in the top module.

Test Plan:
- Reset & idle: drop rst_n asynchronously mid-cycle → stall=0, fwd=0/0 and stall_cnt=0 immediately. Keep id_valid=0 for 5 cycles → outputs unchanged.
- ALU chain: issue ADD x5, then an instruction using rs1=x5 next cycle → fwd1_sel=1, stall=0. Two cycles later with rs2=x5 → fwd2_sel=2. Three cycles later → fwd=3. Four cycles later → 0.
- Load-use: issue LW x7, then an instruction using rs2=x7 → stall=1 for exactly one cycle and stall_cnt=1. Next cycle fwd2_sel=2, stall=0.
- x0 and priority: writes to x0 never forward. ADD x3 followed by SUB x3, then a reader of x3 → fwd1_sel=1 (youngest wins).
- Flush vs stall: a load-use pair with flush=1 in the stall cycle → stall=0, EX gets a bubble, stall_cnt is unchanged.
- Freeze & saturation: freeze=1 for 3 cycles during a load-use → state and stall_cnt hold, and the stall resolves after release. Separately, force stall_cnt to all-ones and stall once → it stays all-ones.

Source files
------------

// File: rtl/regfile_hazard_ctrl_pkg.sv
// regfile_hazard_ctrl_pkg
//   Shared types and constants for the register-file hazard controller.
//   - RF_AW       : register address width (32 registers, x0 hardwired zero)
//   - fwd_sel_e   : operand-mux select encoding driven onto fwd1_sel/fwd2_sel
//   - slot_t      : destination metadata carried by each shadow pipeline slot
package regfile_hazard_ctrl_pkg;

    localparam int unsigned RF_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,  // register file read data
        FWD_EXM = 2'd1,  // EX/MEM result
        FWD_MWB = 2'd2,  // MEM/WB result
        FWD_WB  = 2'd3   // WB write data, same cycle as the regfile write
    } fwd_sel_e;

    typedef struct packed {
        logic             v;   // slot holds a real instruction
        logic [RF_AW-1:0] rd;  // destination register
        logic             we;  // instruction writes rd
        logic             ld;  // result only available after MEM
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/regfile_hazard_ctrl_hazard_slot_cmp.sv
// hazard_slot_cmp
//   Compares one shadow pipeline slot against one ID source operand.
//   Ports:
//     slot_v, slot_rd, slot_we : metadata of the slot under test
//     rs, rs_used              : ID source register and whether it is read
//     id_valid                 : ID stage holds a real instruction
//     hit                      : slot produces the value this operand needs
import regfile_hazard_ctrl_pkg::*;

module hazard_slot_cmp #(
    parameter int unsigned AW = RF_AW
) (
    input  logic          slot_v,
    input  logic [AW-1:0] slot_rd,
    input  logic          slot_we,
    input  logic [AW-1:0] rs,
    input  logic          rs_used,
    input  logic          id_valid,
    output logic          hit
);

    // x0 is hardwired zero, so a write to it never creates a dependency.
    assign hit = slot_v & slot_we & (slot_rd != '0) & (slot_rd == rs) & rs_used & id_valid;

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// regfile_hazard_ctrl
//   Hazard controller for the 32x32 register file of the 5-stage pipeline.
//   Tracks destination metadata of the EX, MEM and WB stages, raises a
//   one-bubble load-use stall and produces per-operand forwarding selects.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     id_valid              : ID stage holds a real instruction
//     id_rs1/id_rs2         : ID source registers
//     id_rs1_used/_rs2_used : the corresponding source is read
//     id_rd, id_we          : ID destination and write enable
//     id_is_load            : ID instruction is a load
//     flush                 : kill the ID instruction (taken branch/jump)
//     freeze                : external hold, nothing advances
//     stall                 : hold PC and IF/ID, inject bubble into EX
//     fwd1_sel/fwd2_sel     : operand source selects (fwd_sel_e encoding)
//     stall_cnt             : saturating count of stall cycles
import regfile_hazard_ctrl_pkg::*;

module regfile_hazard_ctrl #(
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             freeze,
    output logic             stall,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d, mem_d, wb_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_ex1, hit_ex2;
    logic hit_mem1, hit_mem2;
    logic hit_wb1, hit_wb2;

    // The WB load flag is only carried for completeness; nothing downstream needs it.
    logic unused_wb_ld;
    assign unused_wb_ld = wb_q.ld;

    // ------------------------------------------------------------------
    // Slot comparators: 3 slots x 2 operands
    // ------------------------------------------------------------------
    hazard_slot_cmp #(.AW(AW)) u_cmp_ex1 (
        .slot_v   (ex_q.v),
        .slot_rd  (ex_q.rd),
        .slot_we  (ex_q.we),
        .rs       (id_rs1),
        .rs_used  (id_rs1_used),
        .id_valid (id_valid),
        .hit      (hit_ex1)
    );

    hazard_slot_cmp #(.AW(AW)) u_cmp_ex2 (
        .slot_v   (ex_q.v),
        .slot_rd  (ex_q.rd),
        .slot_we  (ex_q.we),
        .rs       (id_rs2),
        .rs_used  (id_rs2_used),
        .id_valid (id_valid),
        .hit      (hit_ex2)
    );

    hazard_slot_cmp #(.AW(AW)) u_cmp_mem1 (
        .slot_v   (mem_q.v),
        .slot_rd  (mem_q.rd),
        .slot_we  (mem_q.we),
        .rs       (id_rs1),
        .rs_used  (id_rs1_used),
        .id_valid (id_valid),
        .hit      (hit_mem1)
    );

    hazard_slot_cmp #(.AW(AW)) u_cmp_mem2 (
        .slot_v   (mem_q.v),
        .slot_rd  (mem_q.rd),
        .slot_we  (mem_q.we),
        .rs       (id_rs2),
        .rs_used  (id_rs2_used),
        .id_valid (id_valid),
        .hit      (hit_mem2)
    );

    hazard_slot_cmp #(.AW(AW)) u_cmp_wb1 (
        .slot_v   (wb_q.v),
        .slot_rd  (wb_q.rd),
        .slot_we  (wb_q.we),
        .rs       (id_rs1),
        .rs_used  (id_rs1_used),
        .id_valid (id_valid),
        .hit      (hit_wb1)
    );

    hazard_slot_cmp #(.AW(AW)) u_cmp_wb2 (
        .slot_v   (wb_q.v),
        .slot_rd  (wb_q.rd),
        .slot_we  (wb_q.we),
        .rs       (id_rs2),
        .rs_used  (id_rs2_used),
        .id_valid (id_valid),
        .hit      (hit_wb2)
    );

    // ------------------------------------------------------------------
    // Stall and forwarding
    // ------------------------------------------------------------------
    // Youngest producer wins. A load in EX has no result yet, so it is
    // skipped here; that case is covered by the stall instead.
    function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic ex_ld,
                                          input logic hit_mem, input logic hit_wb);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (hit_ex && !ex_ld) begin
            sel = FWD_EXM;
        end else if (hit_mem) begin
            sel = FWD_MWB;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // flush kills the consumer, so a pending load-use stall is moot.
    assign stall = (hit_ex1 | hit_ex2) & ex_q.ld & ~flush;

    always_comb begin
        fwd1_sel = FWD_RF;
        fwd2_sel = FWD_RF;
        if (!stall) begin
            fwd1_sel = fwd_pick(hit_ex1, ex_q.ld, hit_mem1, hit_wb1);
            fwd2_sel = fwd_pick(hit_ex2, ex_q.ld, hit_mem2, hit_wb2);
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipeline advance
    // ------------------------------------------------------------------
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall || flush || !id_valid) begin
                ex_d = SLOT_BUBBLE;
            end else begin
                ex_d.v  = 1'b1;
                ex_d.rd = id_rd;
                ex_d.we = id_we;
                ex_d.ld = id_is_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
            wb_q  <= SLOT_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (stall && !freeze && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
module tb_regfile_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_we, id_is_load;
    logic          flush, freeze;
    logic          stall;
    logic [1:0]    fwd1_sel, fwd2_sel;
    logic [CW-1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    regfile_hazard_ctrl #(.AW(5), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .freeze      (freeze),
        .stall       (stall),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the last three issued instructions by age
    // (1 = one cycle old / EX, 2 = MEM, 3 = WB). The forward select
    // equals the age of the youngest usable producer.
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ent_t;

    ent_t age [1:3];
    int   exp_cnt;

    task automatic model_reset();
        for (int a = 1; a <= 3; a++) age[a] = '{v: 0, rd: 0, we: 0, ld: 0};
        exp_cnt = 0;
    endtask

    function automatic int pick(input int rs, input bit used, output bit ld_hit);
        ld_hit = 0;
        if (!id_valid || !used) return 0;
        for (int a = 1; a <= 3; a++) begin
            if (age[a].v && age[a].we && age[a].rd != 0 && age[a].rd == rs) begin
                if (a == 1 && age[a].ld) ld_hit = 1;
                else return a;
            end
        end
        return 0;
    endfunction

    task automatic model_eval(output bit es, output int e1, output int e2);
        bit h1, h2;
        e1 = pick(int'(id_rs1), id_rs1_used, h1);
        e2 = pick(int'(id_rs2), id_rs2_used, h2);
        es = (h1 || h2) && !flush;
        if (es) begin
            e1 = 0;
            e2 = 0;
        end
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit we, input bit ld, input bit fl, input bit fr);
        id_valid    = v;
        id_rs1      = rs1[4:0];
        id_rs2      = rs2[4:0];
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = rd[4:0];
        id_we       = we;
        id_is_load  = ld;
        flush       = fl;
        freeze      = fr;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance model and DUT by one clock; returns at posedge + 1.
    task automatic tick();
        bit es;
        int e1, e2;
        model_eval(es, e1, e2);
        if (!freeze) begin
            if (es && exp_cnt < CMAX) exp_cnt++;
            age[3] = age[2];
            age[2] = age[1];
            if (es || flush || !id_valid) age[1] = '{v: 0, rd: 0, we: 0, ld: 0};
            else age[1] = '{v: 1, rd: int'(id_rd), we: id_we, ld: id_is_load};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (stall !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0 || stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got stall=%0b f1=%0d f2=%0d cnt=%0d want 0/0/0/0",
                     stall, fwd1_sel, fwd2_sel, stall_cnt);
        end
        rst_n = 1'b1;
        // Build in-flight state, then drop reset mid-cycle.
        set_id(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        n_vec++;
        if (fwd2_sel !== 2'd2 || stall_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL reset_prefill: got f2=%0d cnt=%0d want 2/1", fwd2_sel, stall_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (stall !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0 || stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got stall=%0b f1=%0d f2=%0d cnt=%0d want 0/0/0/0",
                     stall, fwd1_sel, fwd2_sel, stall_cnt);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_idle();
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (stall !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0 || stall_cnt !== '0) begin
                n_bad++;
                $display("FAIL idle_%0d: got stall=%0b f1=%0d f2=%0d cnt=%0d want 0/0/0/0",
                         i, stall, fwd1_sel, fwd2_sel, stall_cnt);
            end
            tick();
        end
    endtask

    task automatic test_alu_chain();
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);  // ADD x5
        tick();
        set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (fwd1_sel !== 2'd1 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_exm: got f1=%0d stall=%0b want 1/0", fwd1_sel, stall);
        end
        tick();
        set_id(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (fwd2_sel !== 2'd2 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_mwb: got f2=%0d stall=%0b want 2/0", fwd2_sel, stall);
        end
        tick();
        set_id(1, 5, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (fwd1_sel !== 2'd3 || fwd2_sel !== 2'd3) begin
            n_bad++;
            $display("FAIL alu_wb: got f1=%0d f2=%0d want 3/3", fwd1_sel, fwd2_sel);
        end
        tick();
        set_id(1, 5, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL alu_retired: got f1=%0d f2=%0d want 0/0", fwd1_sel, fwd2_sel);
        end
        tick();
    endtask

    task automatic test_load_use();
        int c0;
        set_id(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);  // LW x7
        tick();
        c0 = exp_cnt;
        set_id(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b1 || fwd2_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL lu_stall: got stall=%0b f2=%0d want 1/0", stall, fwd2_sel);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0 || fwd2_sel !== 2'd2 || int'(stall_cnt) !== c0 + 1) begin
            n_bad++;
            $display("FAIL lu_resolve: got stall=%0b f2=%0d cnt=%0d want 0/2/%0d",
                     stall, fwd2_sel, stall_cnt, c0 + 1);
        end
        tick();
    endtask

    task automatic test_x0_priority();
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);  // LW x0
        tick();
        set_id(1, 0, 0, 1, 1, 3, 1, 0, 0, 0);  // reads x0, is ADD x3
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL x0_nofwd: got stall=%0b f1=%0d f2=%0d want 0/0/0",
                     stall, fwd1_sel, fwd2_sel);
        end
        tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);  // SUB x3
        tick();
        set_id(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (fwd1_sel !== 2'd1 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL youngest_wins: got f1=%0d stall=%0b want 1/0", fwd1_sel, stall);
        end
        tick();
    endtask

    task automatic test_flush_vs_stall();
        int c0;
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);  // LW x9
        tick();
        c0 = exp_cnt;
        // Flushed consumer is itself a load of x9: it must not reach EX.
        set_id(1, 9, 0, 1, 0, 9, 1, 1, 1, 0);
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: got stall=%0b want 0", stall);
        end
        tick();
        set_id(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0 || fwd1_sel !== 2'd2 || int'(stall_cnt) !== c0) begin
            n_bad++;
            $display("FAIL flush_bubble: got stall=%0b f1=%0d cnt=%0d want 0/2/%0d",
                     stall, fwd1_sel, stall_cnt, c0);
        end
        tick();
    endtask

    task automatic test_freeze();
        int c0;
        set_id(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);  // LW x10
        tick();
        c0 = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 10, 0, 1, 0, 0, 0, 0, 1);
            @(negedge clk);
            n_vec++;
            if (stall !== 1'b1 || int'(stall_cnt) !== c0) begin
                n_bad++;
                $display("FAIL freeze_hold_%0d: got stall=%0b cnt=%0d want 1/%0d",
                         i, stall, stall_cnt, c0);
            end
            tick();
        end
        set_id(1, 0, 10, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL freeze_release: got stall=%0b want 1", stall);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0 || fwd2_sel !== 2'd2 || int'(stall_cnt) !== c0 + 1) begin
            n_bad++;
            $display("FAIL freeze_resolve: got stall=%0b f2=%0d cnt=%0d want 0/2/%0d",
                     stall, fwd2_sel, stall_cnt, c0 + 1);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 18; i++) begin
            set_id(1, 0, 0, 0, 0, (i % 31) + 1, 1, 1, 0, 0);
            tick();
            set_id(1, (i % 31) + 1, 0, 1, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_vec++;
            if (stall !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_stall_%0d: got stall=%0b want 1", i, stall);
            end
            tick();
            idle();
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 4'hF) begin
            n_bad++;
            $display("FAIL sat_hold: got cnt=%0d want 15", stall_cnt);
        end
    endtask

    task automatic test_random();
        bit es;
        int e1, e2;
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            @(negedge clk);
            model_eval(es, e1, e2);
            n_vec++;
            if (stall !== es || int'(fwd1_sel) !== e1 || int'(fwd2_sel) !== e2
                || int'(stall_cnt) !== exp_cnt) begin
                n_bad++;
                $display("FAIL rand_%0d: got stall=%0b f1=%0d f2=%0d cnt=%0d want %0b/%0d/%0d/%0d",
                         i, stall, fwd1_sel, fwd2_sel, stall_cnt, es, e1, e2, exp_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_alu_chain();
        test_load_use();
        test_x0_priority();
        test_flush_vs_stall();
        test_freeze();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
